// File: rtl/regdst_pipe.sv
// -----------------------------------------------------------------------------
// regdst_pipe
//
// Purpose:
//   Selects one of NUM_IN candidate destination-register addresses and carries
//   it, together with a write-valid bit, down a STAGES-deep pipeline. Stage 0 is
//   the youngest stage and stage STAGES-1 is writeback, which drives the register
//   file write port. Each stage's address is also compared against two source
//   operand addresses, so hazard and forwarding logic can use the result.
//
// Parameters:
//   ADDR_W        register address width
//   NUM_IN        number of candidate addresses (>= 2)
//   STAGES        pipeline depth (>= 1)
//   FLUSH_STAGES  number of youngest stages that flush invalidates (1..STAGES)
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   in_bus         packed candidates; candidate k is in_bus[k*ADDR_W +: ADDR_W]
//   sel            candidate select
//   in_wen         the instruction writes a register
//   stall          freezes every stage
//   flush          clears the valid bits of the young stages
//   src_a, src_b   source operand addresses used for the match outputs
//   stage_addr     registered address of each stage, packed with stage 0 lowest
//   stage_valid    registered write-valid bit of each stage
//   wb_addr/wb_wen writeback stage address and write enable
//   match_a/b      combinational per-stage hit against src_a / src_b
//
// Optional feature (macro REGDST_FWD_PRIO_EN):
//   Adds fwd_a_hit/fwd_a_stage and fwd_b_hit/fwd_b_stage. Each stage output is
//   the index of the youngest matching stage, and each hit output is the OR of
//   its match vector. All four outputs are combinational.
// -----------------------------------------------------------------------------
module regdst_pipe #(
  parameter  int ADDR_W       = 5,
  parameter  int NUM_IN       = 2,
  parameter  int STAGES       = 3,
  parameter  int FLUSH_STAGES = 2,
  localparam int SEL_W        = $clog2(NUM_IN),
  localparam int FWD_W        = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*ADDR_W-1:0] in_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_wen,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        src_a,
  input  logic [ADDR_W-1:0]        src_b,
`ifdef REGDST_FWD_PRIO_EN
  output logic                     fwd_a_hit,
  output logic [FWD_W-1:0]         fwd_a_stage,
  output logic                     fwd_b_hit,
  output logic [FWD_W-1:0]         fwd_b_stage,
`endif
  output logic [STAGES*ADDR_W-1:0] stage_addr,
  output logic [STAGES-1:0]        stage_valid,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic                     wb_wen,
  output logic [STAGES-1:0]        match_a,
  output logic [STAGES-1:0]        match_b
);

  logic [ADDR_W-1:0] addr_q [STAGES];
  logic [ADDR_W-1:0] addr_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  logic [ADDR_W-1:0] mux_addr;
  logic              sel_in_range;
  logic              mux_valid;

  // An out-of-range select matches no candidate, so the address stays 0.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    mux_addr = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) mux_addr = in_bus[k*ADDR_W +: ADDR_W];
    end
  end

  assign sel_in_range = (int'(sel) < NUM_IN);
  // Register 0 is hard-wired, so a write to it never becomes valid.
  assign mux_valid    = in_wen && sel_in_range && (mux_addr != '0);

  // Next-state logic. The shift and the flush are independent: stall only
  // blocks the shift, and flush always clears the young valid bits, whether
  // or not the pipeline moved this cycle.
  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    if (!stall) begin
      addr_d[0]  = mux_addr;
      valid_d[0] = mux_valid;
      for (int i = 1; i < STAGES; i++) begin
        addr_d[i]  = addr_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
    if (flush) begin
      // Only the valid bits are cleared. The addresses keep moving, and the
      // older stages still commit.
      for (int i = 0; i < FLUSH_STAGES; i++) valid_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stages form a short pipeline of flops, not a memory, so the
      // whole array is reset to a known state.
      for (int i = 0; i < STAGES; i++) addr_q[i] <= '0;
      valid_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every stage
      // samples the value its neighbour held before this edge.
      for (int i = 0; i < STAGES; i++) addr_q[i] <= addr_d[i];
      valid_q <= valid_d;
    end
  end

  always_comb begin
    stage_addr = '0;
    match_a    = '0;
    match_b    = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
      // A source of register 0 never takes a forwarded value.
      match_a[i] = valid_q[i] && (addr_q[i] == src_a) && (src_a != '0);
      match_b[i] = valid_q[i] && (addr_q[i] == src_b) && (src_b != '0);
    end
  end

  assign stage_valid = valid_q;
  assign wb_addr     = addr_q[STAGES-1];
  assign wb_wen      = valid_q[STAGES-1];

`ifdef REGDST_FWD_PRIO_EN
  // Priority encoders that select the youngest match. The scan runs from the
  // oldest stage to the youngest, so the lowest matching index is written last.
  always_comb begin
    fwd_a_stage = '0;
    fwd_b_stage = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (match_a[i]) fwd_a_stage = FWD_W'(i);
      if (match_b[i]) fwd_b_stage = FWD_W'(i);
    end
  end

  assign fwd_a_hit = |match_a;
  assign fwd_b_hit = |match_b;
`endif

endmodule

// File: tb/tb_regdst_pipe.sv
// -----------------------------------------------------------------------------
// tb_regdst_pipe
//
// Self-checking bench for regdst_pipe. The main instance uses the default
// parameters (ADDR_W=5, NUM_IN=2, STAGES=3, FLUSH_STAGES=2). A second instance
// uses NUM_IN=3, so an out-of-range select can be driven. Free-running traffic
// is checked against a scoreboard queue. Stall, flush, reset and forwarding
// are checked with hand-derived constants.
// -----------------------------------------------------------------------------
module tb_regdst_pipe;

  localparam int AW = 5;
  localparam int ST = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          vld;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [2*AW-1:0] in_bus;
  logic          sel;
  logic          in_wen, stall, flush;
  logic [AW-1:0] src_a, src_b;
  logic [ST*AW-1:0] stage_addr;
  logic [ST-1:0] stage_valid;
  logic [AW-1:0] wb_addr;
  logic          wb_wen;
  logic [ST-1:0] match_a, match_b;

  logic [3*AW-1:0] in_bus3;
  logic [1:0]      sel3;
  logic            in_wen3, stall3, flush3;
  logic [AW-1:0]   src_a3, src_b3;
  logic [ST*AW-1:0] stage_addr3;
  logic [ST-1:0]   stage_valid3;
  logic [AW-1:0]   wb_addr3;
  logic            wb_wen3;
  logic [ST-1:0]   match_a3, match_b3;

`ifdef REGDST_FWD_PRIO_EN
  logic       fwd_a_hit, fwd_b_hit, fwd_a_hit3, fwd_b_hit3;
  logic [1:0] fwd_a_stage, fwd_b_stage, fwd_a_stage3, fwd_b_stage3;
`endif

  regdst_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .in_wen(in_wen),
    .stall(stall), .flush(flush), .src_a(src_a), .src_b(src_b),
`ifdef REGDST_FWD_PRIO_EN
    .fwd_a_hit(fwd_a_hit), .fwd_a_stage(fwd_a_stage),
    .fwd_b_hit(fwd_b_hit), .fwd_b_stage(fwd_b_stage),
`endif
    .stage_addr(stage_addr), .stage_valid(stage_valid), .wb_addr(wb_addr),
    .wb_wen(wb_wen), .match_a(match_a), .match_b(match_b)
  );

  regdst_pipe #(.NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .sel(sel3), .in_wen(in_wen3),
    .stall(stall3), .flush(flush3), .src_a(src_a3), .src_b(src_b3),
`ifdef REGDST_FWD_PRIO_EN
    .fwd_a_hit(fwd_a_hit3), .fwd_a_stage(fwd_a_stage3),
    .fwd_b_hit(fwd_b_hit3), .fwd_b_stage(fwd_b_stage3),
`endif
    .stage_addr(stage_addr3), .stage_valid(stage_valid3), .wb_addr(wb_addr3),
    .wb_wen(wb_wen3), .match_a(match_a3), .match_b(match_b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Step one rising edge, then settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of normal traffic and pushes the reference result for
  // this cycle. Once STAGES entries are queued, the oldest one must appear
  // at writeback.
  task automatic drive_sb(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic s, input logic w);
    exp_t e;
    in_bus = {a1, a0};
    sel    = s;
    in_wen = w;
    e.addr = s ? a1 : a0;
    e.vld  = w && (e.addr != '0);
    sb_q.push_back(e);
    tick();
    if (sb_q.size() == ST) begin
      e = sb_q.pop_front();
      check("sb_wb_addr", 32'(wb_addr), 32'(e.addr));
      check("sb_wb_wen", 32'(wb_wen), 32'(e.vld));
    end
  endtask

  // Leaves stage0=a2, stage1=a1 and stage2=a0, all valid.
  task automatic load3(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
    stall = 1'b0; flush = 1'b0; sel = 1'b0; in_wen = 1'b1;
    in_bus = {5'd0, a0}; tick();
    in_bus = {5'd0, a1}; tick();
    in_bus = {5'd0, a2}; tick();
    in_wen = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_bus = '0; sel = 1'b0; in_wen = 1'b0; stall = 1'b0; flush = 1'b0;
    src_a = 5'd3; src_b = 5'd0;
    in_bus3 = '0; sel3 = 2'd0; in_wen3 = 1'b0; stall3 = 1'b0; flush3 = 1'b0;
    src_a3 = 5'd0; src_b3 = 5'd0;

    // Reset state
    #12;
    check("rst_valid", 32'(stage_valid), 32'h0);
    check("rst_addr", 32'(stage_addr), 32'h0);
    check("rst_wb_wen", 32'(wb_wen), 32'h0);
    check("rst_match_a", 32'(match_a), 32'h0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of traffic, between clock edges
    load3(5'd5, 5'd6, 5'd7);
    check("fill_valid", 32'(stage_valid), 32'h7);
    check("fill_addr", 32'(stage_addr), 32'({5'd5, 5'd6, 5'd7}));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(stage_valid), 32'h0);
    check("async_rst_wb_wen", 32'(wb_wen), 32'h0);
    check("async_rst_wb_addr", 32'(wb_addr), 32'h0);
    #1 rst_n = 1'b1;

    // Scoreboard phase. The pipeline is empty after reset, so two empty
    // entries stand in for the contents of stages 1 and 2.
    sb_q.push_back('0);
    sb_q.push_back('0);
    // Latency: address 9 reaches writeback exactly 3 edges later, for one cycle
    drive_sb(5'd3, 5'd9, 1'b1, 1'b1);
    check("lat_stage0", 32'(stage_valid[0]), 32'h1);
    for (int i = 0; i < 4; i++) drive_sb(5'd3, 5'd9, 1'b1, 1'b0);
    // A write to register 0 is never valid
    drive_sb(5'd0, 5'd9, 1'b0, 1'b1);
    check("zero_addr_valid", 32'(stage_valid[0]), 32'h0);
    // Random traffic, with zero addresses frequent enough to appear
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] r0, r1;
      r0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive_sb(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    in_wen = 1'b0;

    // Three-input instance: a valid select, then the out-of-range select 3
    in_bus3 = {5'd7, 5'd6, 5'd5}; sel3 = 2'd2; in_wen3 = 1'b1; tick();
    check("n3_sel2_valid", 32'(stage_valid3[0]), 32'h1);
    sel3 = 2'd3; tick();
    check("n3_oor_valid", 32'(stage_valid3), 32'h2);
    check("n3_oor_addr", 32'(stage_addr3), 32'({5'd0, 5'd7, 5'd0}));
    check("n3_wb", 32'({wb_wen3, wb_addr3}), 32'h0);
    src_a3 = 5'd7; #1;
    check("n3_match_a", 32'(match_a3), 32'h2);
    check("n3_match_b", 32'(match_b3), 32'h0);
    in_wen3 = 1'b0;

    // Stall for two cycles; inputs that change meanwhile are not captured
    load3(5'd12, 5'd8, 5'd4);
    in_bus = {5'd0, 5'd20}; in_wen = 1'b1; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_addr", 32'(stage_addr), 32'({5'd12, 5'd8, 5'd4}));
      check("stall_valid", 32'(stage_valid), 32'h7);
      check("stall_wb_wen", 32'(wb_wen), 32'h1);
    end
    stall = 1'b0; tick();
    check("resume_addr", 32'(stage_addr), 32'({5'd8, 5'd4, 5'd20}));
    check("resume_valid", 32'(stage_valid), 32'h7);

    // Flush with stall clears the young stages without moving anything, then
    // a flush alone on that state shifts the invalid stage 1 into writeback
    load3(5'd12, 5'd8, 5'd4);
    in_bus = {5'd0, 5'd20}; in_wen = 1'b1; flush = 1'b1; stall = 1'b1; tick();
    check("flst_valid", 32'(stage_valid), 32'h4);
    check("flst_addr", 32'(stage_addr), 32'({5'd12, 5'd8, 5'd4}));
    stall = 1'b0; tick();
    check("fl_valid", 32'(stage_valid), 32'h0);
    check("fl_wb_addr", 32'(wb_addr), 32'd8);
    check("fl_addr", 32'(stage_addr), 32'({5'd8, 5'd4, 5'd20}));
    flush = 1'b0;

    // Flush alone on a fully valid pipeline: the older instruction still commits
    load3(5'd12, 5'd8, 5'd4);
    in_wen = 1'b1; flush = 1'b1; tick();
    check("fl_full_valid", 32'(stage_valid), 32'h4);
    check("fl_full_wb", 32'({wb_wen, wb_addr}), 32'({1'b1, 5'd8}));
    flush = 1'b0; in_wen = 1'b0;

    // Forwarding compares
    load3(5'd3, 5'd7, 5'd7);
    src_a = 5'd7; src_b = 5'd0; #1;
    check("fwd_match_a", 32'(match_a), 32'h3);
    check("fwd_match_b", 32'(match_b), 32'h0);
`ifdef REGDST_FWD_PRIO_EN
    check("fwd_a_hit", 32'(fwd_a_hit), 32'h1);
    check("fwd_a_stage", 32'(fwd_a_stage), 32'h0);
    check("fwd_b_hit", 32'({fwd_b_hit, fwd_b_stage}), 32'h0);
`endif
    src_b = 5'd3; #1;
    check("fwd_match_b3", 32'(match_b), 32'h4);
`ifdef REGDST_FWD_PRIO_EN
    check("fwd_b_stage2", 32'({fwd_b_hit, fwd_b_stage}), 32'h6);
`endif
    tick();  // a bubble enters; the two 7s move to stages 1 and 2
    check("fwd_match_a_shift", 32'(match_a), 32'h6);
`ifdef REGDST_FWD_PRIO_EN
    check("fwd_a_stage1", 32'({fwd_a_hit, fwd_a_stage}), 32'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regdst_pipe.md
Name: regdst_pipe

Overview:
- Parametrised successor to the 2:1 destination-register-address select. Selects one of NUM_IN register addresses and carries the result, with a write-valid bit, down a STAGES-deep pipeline (EX→MEM→WB by default).
- Provides per-stage address compare against two source operands for hazard/forwarding logic.
- Sits between decode and the register-file write port; the WB stage output drives the regfile write address and enable.

Parameters:
- ADDR_W, 5, register address width.
- NUM_IN, 2, number of candidate destination addresses (≥2). SEL_W = $clog2(NUM_IN).
- STAGES, 3, pipeline depth (≥1). Stage 0 is youngest; STAGES-1 is WB.
- FLUSH_STAGES, 2, number of youngest stages invalidated by flush (1..STAGES).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bus  input  NUM_IN*ADDR_W  candidate addresses; candidate k is in_bus[k*ADDR_W +: ADDR_W].
- sel  input  SEL_W  candidate select.
- in_wen  input  1  instruction writes a register.
- stall  input  1  freeze the pipeline.
- flush  input  1  squash the young stages.
- src_a  input  ADDR_W  source operand A address.
- src_b  input  ADDR_W  source operand B address.
- stage_addr  output  STAGES*ADDR_W  registered address per stage.
- stage_valid  output  STAGES  registered write-valid per stage.
- wb_addr  output  ADDR_W  equals stage STAGES-1 address.
- wb_wen  output  1  equals stage_valid[STAGES-1].
- match_a  output  STAGES  bit i = stage_valid[i] && stage_addr[i]==src_a && src_a!=0; combinational.
- match_b  output  STAGES  same as match_a, for src_b.

Behaviour:
- Reset (rst_n low, asynchronous): all stage_addr=0, all stage_valid=0. Therefore wb_addr=0, wb_wen=0, match_a=0, match_b=0. Release is synchronous to the next clk edge.
- Mux: mux_addr = candidate[sel]. mux_valid = in_wen && (sel<NUM_IN) && (mux_addr!=0).
  - Out-of-range sel (NUM_IN not a power of 2) yields mux_valid=0 and mux_addr=0.
  - Writes to register 0 are never valid.
- Normal cycle (stall=0, flush=0): stage0 ← {mux_addr, mux_valid}; stage i ← stage i-1 for i=1..STAGES-1. Latency from in_bus/sel to wb_addr is STAGES cycles.
- stall=1, flush=0: all stages hold address and valid; no input captured.
- flush=1, stall=0: shift occurs, then stage_valid[0..FLUSH_STAGES-1] are forced to 0. Addresses still shift, so only the valid bit is cleared. Stages ≥FLUSH_STAGES shift normally, so an older instruction entering WB still commits.
- flush=1, stall=1: no shift. stage_valid[0..FLUSH_STAGES-1] are cleared; other stages hold.
- Valid bit with address 0 is impossible by construction.
- match outputs are purely combinational from the current registers and src inputs; no added latency.
- STAGES=1: stage0 is WB; the flush rules apply identically.

Optional Feature:
- Macro REGDST_FWD_PRIO_EN.
- When defined, adds outputs fwd_a_hit (1), fwd_a_stage ($clog2(STAGES) or 1 if STAGES=1), fwd_b_hit and fwd_b_stage.
  - fwd_x_stage is the index of the lowest-numbered (youngest) set bit of match_x.
  - fwd_x_hit = |match_x.
  - When there is no hit, fwd_x_stage=0.
  - Both are combinational.
- When not defined, these ports do not exist and only the raw match vectors are produced.

Test Plan:
- Reset mid-stream: fill all 3 stages with valid addrs 5,6,7, assert rst_n=0 between edges → stage_valid=000 and wb_wen=0 immediately, without waiting for clk.
- Select/latency: in_bus={in1=9,in0=3}, sel=1, in_wen=1 for one cycle, then in_wen=0 → wb_addr=9, wb_wen=1 exactly 3 cycles later, for one cycle only.
- Zero/out-of-range: sel=0 with in0=0 and in_wen=1 → stage_valid[0]=0. With NUM_IN=3, sel=3 → stage_valid[0]=0.
- Stall: stages hold addrs 4,8,12 all valid, stall=1 for 2 cycles → outputs unchanged and wb_wen stays 1. They resume shifting on the cycle after stall drops.
- Flush+stall: stages valid 4,8,12, flush=1 and stall=1 → stage_valid=100 (only stage2 kept), addresses unchanged. Flush alone on the same state → stage_valid=000 after the shift, wb_addr=8.
- Forwarding: stage_addr=7,7,3 all valid, src_a=7, src_b=0 → match_a=011, match_b=000. With REGDST_FWD_PRIO_EN: fwd_a_hit=1, fwd_a_stage=0, fwd_b_hit=0.
